// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum
//   Accumulates the bitwise XOR of every word in a packet. Words arrive over a
//   valid/ready handshake, and in_last_i marks the last word of a packet. When
//   the last beat is accepted, the block registers the checksum, its reduction
//   parity, the saturated beat count and an overlength flag as one result.
//   The result is held on a valid/ready output until the sink takes it.
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   in_valid_i    input beat valid
//   in_ready_o    block can accept an input beat (combinational)
//   in_data_i     input word, WIDTH bits
//   in_last_i     final beat of the packet
//   out_valid_o   result valid
//   out_ready_i   sink accepts result
//   out_xor_o     XOR of all words in the packet
//   out_parity_o  reduction XOR of out_xor_o
//   out_len_o     beats in the packet, saturated at MAX_LEN
//   out_err_o     packet exceeded MAX_LEN beats
module xor_stream_checksum #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_LEN = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_xor_o,
    output logic             out_parity_o,
    output logic [LEN_W-1:0] out_len_o,
    output logic             out_err_o
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    // Beat counter increment that sticks at MAX_LEN.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        if (c == MAX_CNT) begin
            sat_inc = MAX_CNT;
        end else begin
            sat_inc = c + LEN_W'(1);
        end
    endfunction

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_xor_q, out_xor_d;
    logic             out_parity_q, out_parity_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_err_q, out_err_d;

    logic             accept_in;
    logic             accept_out;
    logic [WIDTH-1:0] acc_next;
    logic             err_next;

    // There is a single result register. Input stalls whenever that register
    // holds a result that is not draining this cycle. Stalling every beat, and
    // not only the last one, keeps the accumulator simple.
    assign in_ready_o = ~out_valid_q | out_ready_i;
    assign accept_in  = in_valid_i & in_ready_o;
    assign accept_out = out_valid_q & out_ready_i;

    assign acc_next = acc_q ^ in_data_i;
    // A beat that arrives while the counter is already at MAX_LEN is beat MAX_LEN+1.
    assign err_next = err_q | (cnt_q == MAX_CNT);

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        out_valid_d  = out_valid_q;
        out_xor_d    = out_xor_q;
        out_parity_d = out_parity_q;
        out_len_d    = out_len_q;
        out_err_d    = out_err_q;

        if (accept_out) begin
            out_valid_d = 1'b0;
        end

        if (accept_in) begin
            if (in_last_i) begin
                // A new result overrides the drain above, so a result can
                // follow a result on consecutive cycles with no bubble.
                out_valid_d  = 1'b1;
                out_xor_d    = acc_next;
                out_parity_d = ^acc_next;
                out_len_d    = sat_inc(cnt_q);
                out_err_d    = err_next;
                acc_d        = '0;
                cnt_d        = '0;
                err_d        = 1'b0;
            end else begin
                acc_d = acc_next;
                cnt_d = sat_inc(cnt_q);
                err_d = err_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_xor_q    <= '0;
            out_parity_q <= 1'b0;
            out_len_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_xor_q    <= out_xor_d;
            out_parity_q <= out_parity_d;
            out_len_q    <= out_len_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_xor_o    = out_xor_q;
    assign out_parity_o = out_parity_q;
    assign out_len_o    = out_len_q;
    assign out_err_o    = out_err_q;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// tb_xor_stream_checksum
//   Directed scenarios plus a randomized stream for xor_stream_checksum with
//   WIDTH=8 and MAX_LEN=4. The reference model stores the words of the current
//   packet in a queue. When the packet closes, the model computes the checksum,
//   parity, length and overlength flag from that queue.
module tb_xor_stream_checksum;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk_i;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             in_last_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_xor_o;
    logic             out_parity_o;
    logic [LEN_W-1:0] out_len_o;
    logic             out_err_o;

    int checks   = 0;
    int failures = 0;

    xor_stream_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_xor_o   (out_xor_o),
        .out_parity_o(out_parity_o),
        .out_len_o   (out_len_o),
        .out_err_o   (out_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: the words of the current packet plus one pending result.
    logic [WIDTH-1:0] pkt[$];
    bit               exp_valid;
    logic [WIDTH-1:0] exp_xor;
    logic             exp_par;
    int               exp_len;
    bit               exp_err;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt.delete();
            exp_valid = 0;
            exp_xor   = '0;
            exp_par   = 1'b0;
            exp_len   = 0;
            exp_err   = 0;
        end else begin
            bit take_out;
            bit take_in;
            logic [WIDTH-1:0] x;
            take_out = exp_valid && out_ready_i;
            take_in  = in_valid_i && (!exp_valid || out_ready_i);
            if (take_out) exp_valid = 0;
            if (take_in) begin
                pkt.push_back(in_data_i);
                if (in_last_i) begin
                    x = '0;
                    foreach (pkt[k]) x = x ^ pkt[k];
                    exp_xor   = x;
                    exp_par   = ^x;
                    exp_len   = (pkt.size() > MAX_LEN) ? MAX_LEN : pkt.size();
                    exp_err   = (pkt.size() > MAX_LEN);
                    exp_valid = 1;
                    pkt.delete();
                end
            end
        end
    end

    // Stimulus helper. Inputs are driven at the negedge and the task waits
    // for acceptance. It returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l, output bit ok);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready_o) begin
                @(negedge clk_i);
                ok = 1;
                break;
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid_o); end
        checks++; if (out_xor_o !== 8'h00) begin failures++; $display("FAIL reset_xor got=%0h exp=0", out_xor_o); end
        checks++; if (out_parity_o !== 1'b0) begin failures++; $display("FAIL reset_parity got=%0b exp=0", out_parity_o); end
        checks++; if (out_len_o !== 3'd0) begin failures++; $display("FAIL reset_len got=%0d exp=0", out_len_o); end
        checks++; if (out_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", out_err_o); end
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        out_ready_i = 1'b1;
    endtask

    task automatic test_basic();
        bit ok0, ok1, ok2;
        send_beat(8'h0F, 1'b0, ok0);
        send_beat(8'hF0, 1'b0, ok1);
        send_beat(8'h3C, 1'b1, ok2);
        checks++; if (!(ok0 && ok1 && ok2)) begin failures++; $display("FAIL basic_accept got=%0b%0b%0b exp=111", ok0, ok1, ok2); end
        checks++; if (out_valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid_o); end
        checks++; if (out_xor_o !== 8'hC3) begin failures++; $display("FAIL basic_xor got=%0h exp=c3", out_xor_o); end
        checks++; if (out_parity_o !== 1'b0) begin failures++; $display("FAIL basic_parity got=%0b exp=0", out_parity_o); end
        checks++; if (out_len_o !== 3'd3) begin failures++; $display("FAIL basic_len got=%0d exp=3", out_len_o); end
        checks++; if (out_err_o !== 1'b0) begin failures++; $display("FAIL basic_err got=%0b exp=0", out_err_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_beat(8'h01, 1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_accept1 got=0 exp=1"); end
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h01 || out_parity_o !== 1'b1 || out_len_o !== 3'd1)
            begin failures++; $display("FAIL b2b_first got=v%0b x%0h p%0b l%0d exp=v1 x01 p1 l1", out_valid_o, out_xor_o, out_parity_o, out_len_o); end
        send_beat(8'h80, 1'b1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_accept2 got=0 exp=1"); end
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h80 || out_parity_o !== 1'b1 || out_len_o !== 3'd1)
            begin failures++; $display("FAIL b2b_second got=v%0b x%0h p%0b l%0d exp=v1 x80 p1 l1", out_valid_o, out_xor_o, out_parity_o, out_len_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%0b exp=0", out_valid_o); end
    endtask

    task automatic test_length_limit();
        bit ok;
        for (int i = 0; i < 4; i++) send_beat(8'h11, (i == 3), ok);
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h00 || out_len_o !== 3'd4 || out_err_o !== 1'b0)
            begin failures++; $display("FAIL len_exact got=v%0b x%0h l%0d e%0b exp=v1 x00 l4 e0", out_valid_o, out_xor_o, out_len_o, out_err_o); end
        for (int i = 0; i < 6; i++) send_beat(8'h11, (i == 5), ok);
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h00 || out_len_o !== 3'd4 || out_err_o !== 1'b1)
            begin failures++; $display("FAIL len_over6 got=v%0b x%0h l%0d e%0b exp=v1 x00 l4 e1", out_valid_o, out_xor_o, out_len_o, out_err_o); end
        // MAX_LEN+1 beats is the first overlength case; odd count leaves a nonzero XOR.
        for (int i = 0; i < 5; i++) send_beat(8'h11, (i == 4), ok);
        checks++; if (out_xor_o !== 8'h11 || out_len_o !== 3'd4 || out_err_o !== 1'b1)
            begin failures++; $display("FAIL len_over5 got=x%0h l%0d e%0b exp=x11 l4 e1", out_xor_o, out_len_o, out_err_o); end
        @(negedge clk_i);
        // The previous overlength packet must not leak err into the next one.
        send_beat(8'h22, 1'b1, ok);
        checks++; if (out_len_o !== 3'd1 || out_err_o !== 1'b0)
            begin failures++; $display("FAIL len_err_cleared got=l%0d e%0b exp=l1 e0", out_len_o, out_err_o); end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready_i = 1'b0;
        send_beat(8'h55, 1'b1, ok);
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h55) begin failures++; $display("FAIL bp_load got=v%0b x%0h exp=v1 x55", out_valid_o, out_xor_o); end
        in_valid_i = 1'b1;
        in_data_i  = 8'hAA;
        in_last_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=0", i, in_ready_o); end
            @(negedge clk_i);
            checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'h55 || out_len_o !== 3'd1 || out_parity_o !== 1'b0)
                begin failures++; $display("FAIL bp_hold cycle=%0d got=v%0b x%0h l%0d p%0b exp=v1 x55 l1 p0", i, out_valid_o, out_xor_o, out_len_o, out_parity_o); end
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready_o); end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'hAA || out_len_o !== 3'd1)
            begin failures++; $display("FAIL bp_swap got=v%0b x%0h l%0d exp=v1 xaa l1", out_valid_o, out_xor_o, out_len_o); end
        @(negedge clk_i);
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid_o); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        send_beat(8'h12, 1'b0, ok);
        send_beat(8'h34, 1'b0, ok);
        rst_ni = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin failures++; $display("FAIL rstmid_async got=v%0b r%0b exp=v0 r1", out_valid_o, in_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_beat(8'hAA, 1'b1, ok);
        checks++; if (out_valid_o !== 1'b1 || out_xor_o !== 8'hAA || out_len_o !== 3'd1 || out_err_o !== 1'b0)
            begin failures++; $display("FAIL rstmid_result got=v%0b x%0h l%0d e%0b exp=v1 xaa l1 e0", out_valid_o, out_xor_o, out_len_o, out_err_o); end
        @(negedge clk_i);
    endtask

    task automatic test_random_stream();
        int results;
        results = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++; if (out_valid_o !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid_o, exp_valid); end
            if (exp_valid) begin
                results++;
                checks++;
                if (out_xor_o !== exp_xor || out_parity_o !== exp_par || out_len_o !== LEN_W'(exp_len) || out_err_o !== exp_err) begin
                    failures++;
                    $display("FAIL rand_result cyc=%0d got=x%0h p%0b l%0d e%0b exp=x%0h p%0b l%0d e%0b",
                             cyc, out_xor_o, out_parity_o, out_len_o, out_err_o, exp_xor, exp_par, exp_len, exp_err);
                end
            end
            in_valid_i  = ($urandom_range(0, 9) < 7);
            in_data_i   = 8'($urandom);
            in_last_i   = ($urandom_range(0, 4) == 0);
            out_ready_i = ($urandom_range(0, 9) < 7);
            #1;
            checks++; if (in_ready_o !== (!exp_valid || out_ready_i)) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready_o, (!exp_valid || out_ready_i)); end
            @(negedge clk_i);
        end
        in_valid_i  = 1'b0;
        in_last_i   = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (results == 0) begin failures++; $display("FAIL rand_no_results got=0 exp>0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_length_limit();
        test_backpressure();
        test_reset_mid_packet();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
